game_seq_ctrl: RTL and testbench

- Round controller for the memory game. It drives the one-hot phase strobes qini/qw/qr that the phase counters and display logic consume.
- Each round it appends one random symbol to the stored sequence and plays the whole sequence on the display. It then checks the player's button presses against the stored sequence.
- It declares win after MAX_LEN correct rounds, and lose on a mismatch or a timeout.

---
 rtl/game_seq_ctrl.sv | 150 +++++++++++++++
 tb/tb_game_seq_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/game_seq_ctrl.sv
// Round controller for the memory game: grows a random symbol sequence, plays it back
// on the display and checks the player's presses, declaring win or lose.
module game_seq_ctrl #(
    parameter int MAX_LEN     = 8,
    parameter int SYM_W       = 2,
    parameter int INI_CYCLES  = 16,
    parameter int SHOW_CYCLES = 4,
    parameter int TIMEOUT     = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [SYM_W-1:0] rand_sym,
    input  logic             btn_valid,
    input  logic [SYM_W-1:0] btn_sym,
    output logic             qini,
    output logic             qw,
    output logic             qr,
    output logic             disp_valid,
    output logic [SYM_W-1:0] disp_sym,
    output logic [3:0]       level,
    output logic             win,
    output logic             lose
);

    localparam int TMAX_IS = (INI_CYCLES > SHOW_CYCLES) ? INI_CYCLES : SHOW_CYCLES;
    localparam int TMAX    = (TMAX_IS > TIMEOUT) ? TMAX_IS : TIMEOUT;
    localparam int TW      = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int AW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [TW-1:0] T_ONE     = TW'(1);
    localparam logic [TW-1:0] INI_LAST  = TW'(INI_CYCLES - 1);
    localparam logic [TW-1:0] SHOW_LAST = TW'(SHOW_CYCLES - 1);
    localparam logic [TW-1:0] SHOW_GAP  = TW'(SHOW_CYCLES - 2);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [3:0]    LVL_MAX   = 4'(MAX_LEN);

    // One flop per state so each phase strobe comes straight off a register.
    typedef enum logic [5:0] {
        S_IDLE  = 6'b000001,
        S_INI   = 6'b000010,
        S_WRITE = 6'b000100,
        S_READ  = 6'b001000,
        S_WIN   = 6'b010000,
        S_LOSE  = 6'b100000
    } state_e;

    state_e           state_q;
    logic [3:0]       level_q;
    logic [3:0]       idx_q;
    logic [TW-1:0]    timer_q;
    logic             disp_valid_q;
    logic [SYM_W-1:0] disp_sym_q;
    logic [SYM_W-1:0] mem_q [MAX_LEN];

    logic [3:0] idx_inc;
    logic [3:0] lvl_m1;

    assign idx_inc = idx_q + 4'd1;
    assign lvl_m1  = level_q - 4'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            level_q      <= 4'd0;
            idx_q        <= 4'd0;
            timer_q      <= '0;
            disp_valid_q <= 1'b0;
            disp_sym_q   <= '0;
            for (int i = 0; i < MAX_LEN; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            disp_valid_q <= 1'b0;
            disp_sym_q   <= '0;
            unique case (state_q)
                S_IDLE, S_WIN, S_LOSE: begin
                    if (start) begin
                        state_q <= S_INI;
                        level_q <= 4'd1;
                        idx_q   <= 4'd0;
                        timer_q <= '0;
                    end
                end
                S_INI: begin
                    if (timer_q == INI_LAST) begin
                        mem_q[lvl_m1[AW-1:0]] <= rand_sym;
                        timer_q      <= '0;
                        idx_q        <= 4'd0;
                        state_q      <= S_WRITE;
                        // Slot 0 of a level-1 round is the entry being written this edge.
                        disp_valid_q <= 1'b1;
                        disp_sym_q   <= (level_q == 4'd1) ? rand_sym : mem_q[0];
                    end else begin
                        timer_q <= timer_q + T_ONE;
                    end
                end
                S_WRITE: begin
                    if (timer_q != SHOW_LAST) begin
                        timer_q      <= timer_q + T_ONE;
                        disp_valid_q <= (timer_q != SHOW_GAP);
                        disp_sym_q   <= disp_sym_q;
                    end else if (idx_q != lvl_m1) begin
                        idx_q        <= idx_inc;
                        timer_q      <= '0;
                        disp_valid_q <= 1'b1;
                        disp_sym_q   <= mem_q[idx_inc[AW-1:0]];
                    end else begin
                        idx_q   <= 4'd0;
                        timer_q <= '0;
                        state_q <= S_READ;
                    end
                end
                S_READ: begin
                    // A press always wins over the timeout on the same cycle.
                    if (btn_valid) begin
                        if (btn_sym != mem_q[idx_q[AW-1:0]]) begin
                            state_q <= S_LOSE;
                        end else if (idx_q != lvl_m1) begin
                            idx_q   <= idx_inc;
                            timer_q <= '0;
                        end else if (level_q == LVL_MAX) begin
                            state_q <= S_WIN;
                        end else begin
                            level_q <= level_q + 4'd1;
                            idx_q   <= 4'd0;
                            timer_q <= '0;
                            state_q <= S_INI;
                        end
                    end else if (timer_q == TO_LAST) begin
                        state_q <= S_LOSE;
                    end else begin
                        timer_q <= timer_q + T_ONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign qini       = state_q[1];
    assign qw         = state_q[2];
    assign qr         = state_q[3];
    assign win        = state_q[4];
    assign lose       = state_q[5];
    assign level      = level_q;
    assign disp_valid = disp_valid_q;
    assign disp_sym   = disp_sym_q;

endmodule

// File: tb/tb_game_seq_ctrl.sv
// Scoreboard bench for game_seq_ctrl: stimulus pushes hand-derived output snapshots,
// a monitor pops and compares them against the DUT outputs.
`timescale 1ns/1ps
module tb_game_seq_ctrl;

    localparam int MAX_LEN     = 3;
    localparam int SYM_W       = 2;
    localparam int INI_CYCLES  = 4;
    localparam int SHOW_CYCLES = 3;
    localparam int TIMEOUT     = 20;

    logic       clk       = 1'b0;
    logic       reset     = 1'b0;
    logic       start     = 1'b0;
    logic [1:0] rand_sym  = 2'd0;
    logic       btn_valid = 1'b0;
    logic [1:0] btn_sym   = 2'd0;
    logic       qini, qw, qr, disp_valid, win, lose;
    logic [1:0] disp_sym;
    logic [3:0] level;

    always #5 clk = ~clk;

    game_seq_ctrl #(
        .MAX_LEN(MAX_LEN), .SYM_W(SYM_W), .INI_CYCLES(INI_CYCLES),
        .SHOW_CYCLES(SHOW_CYCLES), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .rand_sym(rand_sym),
        .btn_valid(btn_valid), .btn_sym(btn_sym), .qini(qini), .qw(qw), .qr(qr),
        .disp_valid(disp_valid), .disp_sym(disp_sym), .level(level), .win(win), .lose(lose)
    );

    typedef struct packed {
        logic       qini, qw, qr, dv;
        logic [1:0] ds;
        logic [3:0] lvl;
        logic       win, lose;
    } outs_t;

    typedef struct {
        outs_t o;
        string tag;
    } exp_t;

    exp_t  sb[$];
    exp_t  cur;
    outs_t act;
    int    n_cmp = 0;
    int    n_bad = 0;
    logic [1:0] seq [3];

    assign act = {qini, qw, qr, disp_valid, disp_sym, level, win, lose};

    function automatic string fmt(input outs_t o);
        return $sformatf("ini=%0b w=%0b r=%0b dv=%0b ds=%0d lvl=%0d win=%0b lose=%0b",
                         o.qini, o.qw, o.qr, o.dv, o.ds, o.lvl, o.win, o.lose);
    endfunction

    function automatic outs_t mk(input logic i, input logic w, input logic r, input logic dv,
                                 input logic [1:0] ds, input logic [3:0] l,
                                 input logic wn, input logic ls);
        outs_t o;
        o = {i, w, r, dv, ds, l, wn, ls};
        return o;
    endfunction

    function automatic outs_t o_zero();
        return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0);
    endfunction
    function automatic outs_t o_ini(input logic [3:0] l);
        return mk(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, l, 1'b0, 1'b0);
    endfunction
    function automatic outs_t o_wr(input logic dv, input logic [1:0] ds, input logic [3:0] l);
        return mk(1'b0, 1'b1, 1'b0, dv, ds, l, 1'b0, 1'b0);
    endfunction
    function automatic outs_t o_rd(input logic [3:0] l);
        return mk(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, l, 1'b0, 1'b0);
    endfunction
    function automatic outs_t o_win(input logic [3:0] l);
        return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, l, 1'b1, 1'b0);
    endfunction
    function automatic outs_t o_lose(input logic [3:0] l);
        return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, l, 1'b0, 1'b1);
    endfunction

    // Monitor: one check per pushed snapshot, sampled well away from the rising edge.
    always @(negedge clk or negedge reset) begin
        #1;
        if (sb.size() > 0) begin
            cur = sb.pop_front();
            n_cmp++;
            if (act !== cur.o) begin
                n_bad++;
                $display("FAIL %s: got %s required %s", cur.tag, fmt(act), fmt(cur.o));
            end
        end
    end

    // One clock of stimulus; want is the output snapshot after this rising edge.
    task automatic tick(input logic st, input logic [1:0] rs, input logic bv,
                        input logic [1:0] bs, input outs_t want, input string tag);
        exp_t e;
        start     = st;
        rand_sym  = rs;
        btn_valid = bv;
        btn_sym   = bs;
        @(posedge clk);
        e.o   = want;
        e.tag = tag;
        sb.push_back(e);
        #1;
        start     = 1'b0;
        btn_valid = 1'b0;
    endtask

    task automatic idle(input outs_t want, input string tag);
        tick(1'b0, 2'd0, 1'b0, 2'd0, want, tag);
    endtask

    task automatic press(input logic [1:0] s, input outs_t want, input string tag);
        tick(1'b0, 2'd0, 1'b1, s, want, tag);
    endtask

    // Called right after the edge that entered INI; runs INI and WRITE, ends in READ.
    task automatic play_round(input logic [3:0] lvl, input logic [1:0] sym, input logic noise);
        int n;
        n = int'(lvl);
        seq[n-1] = sym;
        for (int k = 1; k < INI_CYCLES; k++)
            tick(noise, ~sym, noise, ~sym, o_ini(lvl), "ini_hold");
        tick(1'b0, sym, 1'b0, 2'd0, o_wr(1'b1, seq[0], lvl), "ini_to_write");
        for (int k = 1; k < SHOW_CYCLES * n; k++)
            tick(noise && (k % 2 == 1), 2'd0, noise, ~seq[k / SHOW_CYCLES],
                 o_wr(k % SHOW_CYCLES != SHOW_CYCLES - 1, seq[k / SHOW_CYCLES], lvl),
                 "write_slot");
        tick(noise, 2'd0, 1'b0, 2'd0, o_rd(lvl), "write_to_read");
    endtask

    task automatic answer(input logic [3:0] lvl);
        int n;
        n = int'(lvl);
        for (int i = 0; i < n; i++) begin
            idle(o_rd(lvl), "read_wait");
            if (i < n - 1)
                press(seq[i], o_rd(lvl), "press_ok");
            else if (n == MAX_LEN)
                press(seq[i], o_win(lvl), "press_win");
            else
                press(seq[i], o_ini(lvl + 4'd1), "press_next");
        end
    endtask

    // Reset lands mid low phase so the monitor sees it before the next rising edge.
    task automatic do_reset();
        exp_t e;
        @(negedge clk);
        #2;
        e.o   = o_zero();
        e.tag = "async_reset";
        sb.push_back(e);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        tick(1'b1, 2'd1, 1'b1, 2'd1, o_zero(), "reset_state");
        tick(1'b1, 2'd2, 1'b0, 2'd0, o_zero(), "reset_hold");
        reset = 1'b1;
        tick(1'b0, 2'd0, 1'b1, 2'd0, o_zero(), "idle_btn_ignored");
        idle(o_zero(), "idle_hold");

        // Game 1: symbols 2,1,3, full win; round 2 carries ignored start/btn noise.
        tick(1'b1, 2'd0, 1'b0, 2'd0, o_ini(4'd1), "start_g1");
        play_round(4'd1, 2'd2, 1'b0);
        answer(4'd1);
        play_round(4'd2, 2'd1, 1'b1);
        tick(1'b1, 2'd0, 1'b0, 2'd0, o_rd(4'd2), "read_start_ignored");
        answer(4'd2);
        play_round(4'd3, 2'd3, 1'b0);
        answer(4'd3);
        for (int k = 0; k < 3; k++)
            tick(1'b0, 2'd0, 1'b1, 2'd0, o_win(4'd3), "win_hold");

        // Game 2: sequence 2,1; wrong second press loses at level 2.
        tick(1'b1, 2'd0, 1'b0, 2'd0, o_ini(4'd1), "start_from_win");
        play_round(4'd1, 2'd2, 1'b0);
        answer(4'd1);
        play_round(4'd2, 2'd1, 1'b0);
        idle(o_rd(4'd2), "read_wait");
        press(2'd2, o_rd(4'd2), "press_ok");
        press(2'd0, o_lose(4'd2), "wrong_press");
        for (int k = 0; k < 2; k++)
            tick(1'b0, 2'd0, 1'b1, 2'd1, o_lose(4'd2), "lose_hold");

        // Game 3: no press at all in READ times out.
        tick(1'b1, 2'd0, 1'b0, 2'd0, o_ini(4'd1), "start_from_lose");
        play_round(4'd1, 2'd3, 1'b0);
        for (int k = 1; k < TIMEOUT; k++)
            idle(o_rd(4'd1), "read_count");
        idle(o_lose(4'd1), "timeout");

        // Game 4: press on the timeout cycle is honoured, then reset mid-READ.
        tick(1'b1, 2'd0, 1'b0, 2'd0, o_ini(4'd1), "start_g4");
        play_round(4'd1, 2'd1, 1'b0);
        for (int k = 1; k < TIMEOUT; k++)
            idle(o_rd(4'd1), "read_count");
        press(2'd1, o_ini(4'd2), "press_at_timeout");
        play_round(4'd2, 2'd0, 1'b0);
        idle(o_rd(4'd2), "read_wait");
        do_reset();
        tick(1'b0, 2'd0, 1'b1, 2'd1, o_zero(), "post_reset_btn");
        idle(o_zero(), "post_reset_idle");
        tick(1'b1, 2'd0, 1'b0, 2'd0, o_ini(4'd1), "restart");
        idle(o_ini(4'd1), "restart_ini");

        @(negedge clk);
        #3;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
